// File: rtl/nios2_ocimem_arbiter_if.sv
// CPU-side Avalon-MM debug memory slave bus for the OCI RAM arbiter.
// The CPU drives it through the master modport; the arbiter takes it through the slave modport.
interface nios2_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/nios2_ocimem_arbiter.sv
// Nios II OCI RAM arbiter: shares the 256x32 on-chip debug memory between the
// JTAG debug slave strobes and the CPU Avalon-MM debug slave. It keeps the
// JTAG pointer and the MonDReg readback register. Ties are resolved round-robin.
module nios2_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [37:0]                jdo,
  input  logic                       take_action_ocimem_a,
  input  logic                       take_action_ocimem_b,
  input  logic                       take_no_action_ocimem_a,
  output logic [DATA_W-1:0]          MonDReg,
  output logic                       ocimem_ready,
  output logic                       jtag_overrun,
  nios2_ocimem_arbiter_if.slave      avs,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic                       ram_wren,
  output logic [DATA_W-1:0]          ram_wdata,
  input  logic [DATA_W-1:0]          ram_rdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  localparam logic OWN_AVS  = 1'b0;
  localparam logic OWN_JTAG = 1'b1;

  state_t            r_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_jpend;
  logic              r_jwr;
  logic [DATA_W-1:0] r_jdata;
  logic [ADDR_W-1:0] r_jptr;
  logic [DATA_W-1:0] r_mondreg;
  logic              r_overrun;

  logic              w_avs_req;
  logic              w_jtag_rd_busy;
  logic              w_busy;
  logic              w_grant_j;
  logic              w_grant_a;
  logic              w_ack;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_wren;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [ADDR_W-1:0] w_jptr_inc;
  logic              w_unused;

  // Only the pointer, read flag and data field of jdo matter here.
  assign w_unused = ^{jdo[37:36], jdo[2:0]};

  assign w_avs_req      = avs.avs_read | avs.avs_write;
  assign w_jtag_rd_busy = (r_state == ST_RD) && (r_owner == OWN_JTAG);
  assign w_busy         = r_jpend | w_jtag_rd_busy;
  assign w_jptr_inc     = r_jptr + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Grants are issued only in IDLE. On a tie the side that did not win last time wins.
  // Grants are held off while reset is asserted.
  assign w_grant_j = reset_n & (r_state == ST_IDLE) & r_jpend
                   & (~w_avs_req | (r_last_grant == OWN_AVS));
  assign w_grant_a = reset_n & (r_state == ST_IDLE) & w_avs_req
                   & (~r_jpend | (r_last_grant == OWN_JTAG));

  // The CPU is acknowledged by a granted write, or by the data cycle of its own read.
  assign w_ack = (w_grant_a & avs.avs_write)
               | ((r_state == ST_RD) & (r_owner == OWN_AVS));

  // RAM port steering from this cycle's winner; idle default drives zeros.
  always_comb begin
    w_ram_addr  = {ADDR_W{1'b0}};
    w_ram_wren  = 1'b0;
    w_ram_wdata = {DATA_W{1'b0}};
    if (w_grant_j) begin
      w_ram_addr  = r_jptr;
      w_ram_wren  = r_jwr;
      w_ram_wdata = r_jwr ? r_jdata : {DATA_W{1'b0}};
    end else if (w_grant_a) begin
      w_ram_addr  = avs.avs_address;
      w_ram_wren  = avs.avs_write;
      w_ram_wdata = avs.avs_write ? avs.avs_writedata : {DATA_W{1'b0}};
    end else begin
      w_ram_addr  = {ADDR_W{1'b0}};
      w_ram_wren  = 1'b0;
      w_ram_wdata = {DATA_W{1'b0}};
    end
  end

  assign ram_addr            = w_ram_addr;
  assign ram_wren            = reset_n & w_ram_wren;
  assign ram_wdata           = w_ram_wdata;
  assign avs.avs_readdata    = ram_rdata;
  assign avs.avs_waitrequest = w_avs_req & ~w_ack;
  assign MonDReg             = r_mondreg;
  assign jtag_overrun        = r_overrun;
  assign ocimem_ready        = ~r_jpend & ~w_jtag_rd_busy;

  // Access FSM, JTAG holding register and strobe capture.
  // An _a pointer load is written last, so it wins over a same-cycle pointer increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_AVS;
      r_last_grant <= OWN_AVS;
      r_jpend      <= 1'b0;
      r_jwr        <= 1'b0;
      r_jdata      <= {DATA_W{1'b0}};
      r_jptr       <= {ADDR_W{1'b0}};
      r_mondreg    <= {DATA_W{1'b0}};
      r_overrun    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_j) begin
            r_last_grant <= OWN_JTAG;
            if (r_jwr) begin
              r_jpend <= 1'b0;
              r_jptr  <= w_jptr_inc;
            end else begin
              r_state <= ST_RD;
              r_owner <= OWN_JTAG;
            end
          end else if (w_grant_a) begin
            r_last_grant <= OWN_AVS;
            if (!avs.avs_write) begin
              r_state <= ST_RD;
              r_owner <= OWN_AVS;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD: begin
          r_state <= ST_IDLE;
          if (r_owner == OWN_JTAG) begin
            r_mondreg <= ram_rdata;
            r_jpend   <= 1'b0;
            r_jptr    <= w_jptr_inc;
          end else begin
            r_mondreg <= r_mondreg;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Strobes are taken in priority order; queueing while busy only flags overrun.
      if (take_action_ocimem_a) begin
        r_jptr    <= jdo[ADDR_W+16:17];
        r_overrun <= jdo[35] & w_busy;
        if (jdo[35] && !w_busy) begin
          r_jpend <= 1'b1;
          r_jwr   <= 1'b0;
        end else begin
          r_jwr   <= r_jwr;
        end
      end else if (take_action_ocimem_b) begin
        if (w_busy) begin
          r_overrun <= 1'b1;
        end else begin
          r_jpend <= 1'b1;
          r_jwr   <= 1'b1;
          r_jdata <= jdo[DATA_W+2:3];
        end
      end else if (take_no_action_ocimem_a) begin
        if (w_busy) begin
          r_overrun <= 1'b1;
        end else begin
          r_jpend <= 1'b1;
          r_jwr   <= 1'b0;
        end
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Table-driven bench for nios2_ocimem_arbiter with a behavioural 256x32
// synchronous-read RAM, plus a hand-written reset-during-read sequence.
module tb_nios2_ocimem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta, tb, tn;
  logic [31:0] mondreg;
  logic        ready;
  logic        overrun;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mem [256];

  int n_chk;
  int n_fail;

  nios2_ocimem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) avs_if ();

  nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta),
    .take_action_ocimem_b    (tb),
    .take_no_action_ocimem_a (tn),
    .MonDReg                 (mondreg),
    .ocimem_ready            (ready),
    .jtag_overrun            (overrun),
    .avs                     (avs_if.slave),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous read, data one clock after the address.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ta;
    logic        tb;
    logic        tn;
    logic [37:0] jdo;
    logic        e_wait;
    logic        e_wren;
    logic [7:0]  e_raddr;
    logic [31:0] e_wdata;
    logic        e_ready;
    logic [31:0] e_mon;
    logic        e_ovr;
    logic        chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [40];
  int   nv;

  function automatic logic [37:0] ja(input logic rd, input logic [7:0] p);
    logic [37:0] j;
    j = 38'd0;
    j[35] = rd;
    j[24:17] = p;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j = 38'd0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic add(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic sa, input logic sb, input logic sn, input logic [37:0] jd,
                     input logic ew, input logic ewr, input logic [7:0] ea, input logic [31:0] ewd,
                     input logic erdy, input logic [31:0] emon, input logic eovr,
                     input logic crd, input logic [31:0] erd);
    vecs[nv] = {rd, wr, a, wd, sa, sb, sn, jd, ew, ewr, ea, ewd, erdy, emon, eovr, crd, erd};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
    avs_if.avs_address = 8'h00; avs_if.avs_writedata = 32'h0;
    ta = 1'b0; tb = 1'b0; tn = 1'b0; jdo = 38'd0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; nv = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[8'h10] = 32'hDEADBEEF;
    drive_idle();
    reset_n = 1'b0;

    //   rd wr addr  wdata          ta tb tn jdo                wait wren raddr wdata         rdy mon            ovr chk rdata
    add(0, 0, 8'h00, 32'h0,         1, 0, 0, ja(1'b1, 8'h10),   0, 0, 8'h00, 32'h0,         1, 32'h0,        0, 0, 32'h0);          // c0 _a read 0x10
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h10, 32'h0,         0, 32'h0,        0, 0, 32'h0);          // c1 grant
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         0, 32'h0,        0, 0, 32'h0);          // c2 RD
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hDEADBEEF, 0, 0, 32'h0);          // c3 MonDReg
    add(0, 0, 8'h00, 32'h0,         0, 0, 1, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hDEADBEEF, 0, 0, 32'h0);          // c4 no_action
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h11, 32'h0,         0, 32'hDEADBEEF, 0, 0, 32'h0);          // c5 ptr 0x11
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         0, 32'hDEADBEEF, 0, 0, 32'h0);          // c6
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0011, 0, 0, 32'h0);          // c7
    add(0, 0, 8'h00, 32'h0,         1, 0, 0, ja(1'b0, 8'hFF),   0, 0, 8'h00, 32'h0,         1, 32'hC0DE0011, 0, 0, 32'h0);          // c8 ptr=FF
    add(0, 0, 8'h00, 32'h0,         0, 1, 0, jb(32'h12345678),  0, 0, 8'h00, 32'h0,         1, 32'hC0DE0011, 0, 0, 32'h0);          // c9 _b
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 1, 8'hFF, 32'h12345678,  0, 32'hC0DE0011, 0, 0, 32'h0);          // c10 write FF
    add(0, 0, 8'h00, 32'h0,         0, 0, 1, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0011, 0, 0, 32'h0);          // c11
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         0, 32'hC0DE0011, 0, 0, 32'h0);          // c12 wrapped ptr
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         0, 32'hC0DE0011, 0, 0, 32'h0);          // c13
    add(0, 1, 8'h20, 32'hA5A5A5A5,  0, 0, 0, 38'd0,             0, 1, 8'h20, 32'hA5A5A5A5,  1, 32'hC0DE0000, 0, 0, 32'h0);          // c14 avs write
    add(1, 0, 8'h20, 32'h0,         0, 0, 0, 38'd0,             1, 0, 8'h20, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c15 avs read
    add(1, 0, 8'h20, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 1, 32'hA5A5A5A5);   // c16 data
    add(1, 0, 8'hFF, 32'h0,         0, 0, 0, 38'd0,             1, 0, 8'hFF, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c17
    add(1, 0, 8'hFF, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 1, 32'h12345678);   // c18 JTAG write landed
    add(0, 0, 8'h00, 32'h0,         1, 0, 0, ja(1'b0, 8'h30),   0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c19
    add(0, 0, 8'h00, 32'h0,         0, 1, 0, jb(32'h55AA55AA),  0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c20
    add(1, 0, 8'h40, 32'h0,         0, 0, 0, 38'd0,             1, 1, 8'h30, 32'h55AA55AA,  0, 32'hC0DE0000, 0, 0, 32'h0);          // c21 tie: JTAG
    add(1, 0, 8'h40, 32'h0,         0, 0, 0, 38'd0,             1, 0, 8'h40, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c22 AVS grant
    add(1, 0, 8'h40, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 1, 32'hC0DE0040);   // c23
    add(0, 0, 8'h00, 32'h0,         0, 1, 0, jb(32'h11112222),  0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c24
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 1, 8'h31, 32'h11112222,  0, 32'hC0DE0000, 0, 0, 32'h0);          // c25 JTAG alone
    add(0, 0, 8'h00, 32'h0,         0, 1, 0, jb(32'h33334444),  0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c26
    add(0, 1, 8'h50, 32'h99998888,  0, 0, 0, 38'd0,             0, 1, 8'h50, 32'h99998888,  0, 32'hC0DE0000, 0, 0, 32'h0);          // c27 tie: AVS
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 1, 8'h32, 32'h33334444,  0, 32'hC0DE0000, 0, 0, 32'h0);          // c28 JTAG next
    add(0, 0, 8'h00, 32'h0,         0, 0, 1, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0000, 0, 0, 32'h0);          // c29
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h33, 32'h0,         0, 32'hC0DE0000, 0, 0, 32'h0);          // c30
    add(0, 0, 8'h00, 32'h0,         0, 0, 1, 38'd0,             0, 0, 8'h00, 32'h0,         0, 32'hC0DE0000, 0, 0, 32'h0);          // c31 strobe in flight
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0033, 1, 0, 32'h0);          // c32 overrun, ignored
    add(0, 0, 8'h00, 32'h0,         1, 0, 0, ja(1'b0, 8'h00),   0, 0, 8'h00, 32'h0,         1, 32'hC0DE0033, 1, 0, 32'h0);          // c33 _a
    add(0, 0, 8'h00, 32'h0,         0, 0, 1, 38'd0,             0, 0, 8'h00, 32'h0,         1, 32'hC0DE0033, 0, 0, 32'h0);          // c34 cleared
    add(0, 0, 8'h00, 32'h0,         0, 0, 0, 38'd0,             0, 0, 8'h00, 32'h0,         0, 32'hC0DE0033, 0, 0, 32'h0);          // c35 grant 0x00

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst mon", mondreg, 32'h0);
    chk("rst ovr", {31'd0, overrun}, 32'd0);
    chk("rst wren", {31'd0, ram_wren}, 32'd0);
    chk("rst raddr", {24'd0, ram_addr}, 32'd0);
    chk("rst wdata", ram_wdata, 32'h0);
    chk("rst wait", {31'd0, avs_if.avs_waitrequest}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      @(posedge clk);
      #1;
      avs_if.avs_read = vecs[i].rd; avs_if.avs_write = vecs[i].wr;
      avs_if.avs_address = vecs[i].addr; avs_if.avs_writedata = vecs[i].wdata;
      ta = vecs[i].ta; tb = vecs[i].tb; tn = vecs[i].tn; jdo = vecs[i].jdo;
      #3;
      chk($sformatf("v%0d wait", i), {31'd0, avs_if.avs_waitrequest}, {31'd0, vecs[i].e_wait});
      chk($sformatf("v%0d wren", i), {31'd0, ram_wren}, {31'd0, vecs[i].e_wren});
      chk($sformatf("v%0d raddr", i), {24'd0, ram_addr}, {24'd0, vecs[i].e_raddr});
      chk($sformatf("v%0d wdata", i), ram_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d ready", i), {31'd0, ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("v%0d mon", i), mondreg, vecs[i].e_mon);
      chk($sformatf("v%0d ovr", i), {31'd0, overrun}, {31'd0, vecs[i].e_ovr});
      if (vecs[i].chk_rd) chk($sformatf("v%0d rdata", i), avs_if.avs_readdata, vecs[i].e_rdata);
    end

    // Reset asserted while a JTAG read sits in RD, with a CPU write asserted
    @(posedge clk);
    #1;
    drive_idle();
    avs_if.avs_write = 1'b1; avs_if.avs_address = 8'h55; avs_if.avs_writedata = 32'hFFFFFFFF;
    #1;
    chk("rd busy", {31'd0, ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rstrd wren", {31'd0, ram_wren}, 32'd0);
    chk("rstrd mon", mondreg, 32'h0);
    chk("rstrd ready", {31'd0, ready}, 32'd1);
    chk("rstrd raddr", {24'd0, ram_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive_idle();
    avs_if.avs_read = 1'b1; avs_if.avs_address = 8'h10;
    #3;
    chk("post wait1", {31'd0, avs_if.avs_waitrequest}, 32'd1);
    chk("post raddr", {24'd0, ram_addr}, 32'h10);
    @(posedge clk);
    #3;
    chk("post wait0", {31'd0, avs_if.avs_waitrequest}, 32'd0);
    chk("post rdata", avs_if.avs_readdata, 32'hDEADBEEF);
    chk("post mon", mondreg, 32'h0);
    chk("post 55 untouched", mem[8'h55], 32'hC0DE0055);
    @(posedge clk);
    #1;
    drive_idle();
    #3;
    chk("post idle wait", {31'd0, avs_if.avs_waitrequest}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_arbiter.md
# nios2_ocimem_arbiter

Arbitrates the Nios II on-chip debug memory (OCI RAM, 256 x 32, synchronous read) between two requesters. The first is the JTAG debug slave's system-clock action strobes (`take_action_ocimem_a/b`, `take_no_action_ocimem_a`, `jdo`). The second is the CPU's Avalon-MM debug memory slave. The block holds the JTAG address pointer and the `MonDReg` readback register, runs a small access FSM, and resolves contention round-robin.

## Interface
- `ADDR_W`, 8, OCI RAM word-address width; the pointer wraps at 2^ADDR_W.
- `DATA_W`, 32, data width; `jdo` data field is `jdo[DATA_W+2:3]`.
- `clk`  in  1  system clock; all state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jdo`  in  38  JTAG shift data, already synchronized to `clk`.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load pointer `jdo[ADDR_W+16:17]`; if `jdo[35]`=1, also queue a read.
- `take_action_ocimem_b`  in  1  one-cycle strobe: queue a write of the data field to the pointer.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: queue a read at the pointer.
- `MonDReg`  out  DATA_W  last JTAG read data.
- `ocimem_ready`  out  1  high when no JTAG request is pending or in flight.
- `jtag_overrun`  out  1  sticky: a JTAG strobe arrived while busy.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU requests; held until waitrequest is low.
- `avs_writedata`  in  DATA_W  CPU write data.
- `avs_readdata`  out  DATA_W  CPU read data; valid when read and waitrequest are low.
- `avs_waitrequest`  out  1  stall for the CPU.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wren`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data; valid one clock after the address is presented.

## Operation
- JTAG holding register:
  - Fields: `jpend`, `jwr`, `jdata`, pointer `jptr`.
  - Any queueing strobe while `jpend` or a JTAG read is in flight is discarded and sets `jtag_overrun`.
  - An `_a` strobe still reloads `jptr` and clears `jtag_overrun`.
- Priority when strobes coincide: `_a` before `_b` before `no_action_a`. Only the highest-priority strobe is taken.
- FSM states:
  - `IDLE`:
    - Requesters are `jpend` and `avs_read|avs_write`.
    - If both request, the grant goes to the one not in `last_grant`.
    - Reset value of `last_grant` is AVS, so JTAG wins the first tie.
    - `last_grant` updates on every grant.
  - `IDLE` write grant:
    - `ram_addr`/`ram_wdata`/`ram_wren` are driven combinationally from the winner this cycle. Stay in `IDLE`.
    - JTAG write: clear `jpend`, then `jptr <= jptr+1`, wrapping from 2^ADDR_W-1 to 0.
    - AVS write: `avs_waitrequest`=0 this cycle.
  - `IDLE` read grant: drive `ram_addr` with `ram_wren`=0, record the owner, go to `RD`.
  - `RD`:
    - Owner AVS: `avs_readdata = ram_rdata` (combinational) and `avs_waitrequest`=0.
    - Owner JTAG: `MonDReg <= ram_rdata`, clear `jpend`, `jptr <= jptr+1` (wrap).
    - Return to `IDLE`. No new grant is issued in `RD`.
- Waitrequest:
  - `avs_waitrequest = (avs_read|avs_write) & ~ack`.
  - It is 0 when the CPU is idle.
- `ocimem_ready = ~jpend & ~(state==RD & owner==JTAG)`.
- Reset mid-operation: state to `IDLE`; `jpend`, `jtag_overrun` and `jptr` are cleared. An in-flight read is dropped and `MonDReg` is cleared. `ram_wren` is forced 0 while `reset_n` is low.

## Timing
- Reset values:
  - `MonDReg`=0, `ocimem_ready`=1, `jtag_overrun`=0.
  - `ram_wren`=0, `ram_addr`=0 (idle default), `ram_wdata`=0.
  - `avs_readdata`=`ram_rdata` passthrough, `avs_waitrequest`=0 with no request.
- AVS write: zero wait states when granted at request cycle N; `ram_wren` is high in cycle N.
- AVS read: address at N, data plus waitrequest low at N+1; minimum 2 cycles per read.
- JTAG read: strobe at N, `jpend` from N+1, grant at N+1 earliest, `MonDReg` updated at the N+3 edge, `ocimem_ready` back high at N+3.
- JTAG write: strobe at N, RAM write at N+1, `ocimem_ready` high at N+2.
- Contention adds at most one access (1 or 2 cycles) of delay to either side.

## Test plan
- Reset then JTAG read: `_a` strobe with `jdo[24:17]`=0x10 and `jdo[35]`=1, RAM[0x10]=0xDEADBEEF. Required: `MonDReg`=0xDEADBEEF 3 cycles after the strobe, `jptr`=0x11, `ocimem_ready` high again.
- JTAG write wrap: pointer 0xFF, `_b` with data 0x12345678. Required: RAM[0xFF] written, `jptr`=0x00, a following `no_action_a` reads RAM[0x00].
- AVS back-to-back: write 0xA5A5A5A5 to 0x20, then read 0x20. Required: write with waitrequest 0, then read returns 0xA5A5A5A5 with exactly 1 wait cycle.
- Tie: JTAG write pending and `avs_read` in the same cycle, after reset. Required: JTAG granted first, AVS waitrequest high 1 extra cycle; on the next tie, AVS is granted first.
- Overrun: `no_action_a` while a JTAG read is in flight. Required: the strobe is ignored, `jtag_overrun`=1, and a later `_a` clears it.
- Reset asserted in `RD` state. Required: `ram_wren`=0, `MonDReg`=0, `ocimem_ready`=1 immediately; normal AVS read succeeds after release.
